// File: rtl/fetch_unit.sv
// Fetch stage: drives the instruction memory address each cycle and pairs the
// returned word with its PC. Handles stall, zero-bubble redirect and fetch faults.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES   = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic        resp_valid;
  logic        fault_hit;

  // Address select: a stall re-reads the displayed word so the output stays stable.
  always_comb begin
    imem_addr = fetch_pc;
    if (reset) begin
      imem_addr = RESET_VECTOR;
    end else begin
      case (state)
        FAULT: imem_addr = resp_pc;
        RUN: begin
          if (redirect_valid) imem_addr = redirect_target;
          else if (stall)     imem_addr = resp_pc;
        end
        default: imem_addr = fetch_pc;
      endcase
    end
  end

  assign fault_hit = (state == RUN) &&
                     ((imem_addr[1:0] != 2'b00) || (imem_addr > LAST_WORD));

  assign if_pc    = resp_pc;
  assign if_instr = imem_instr;
  assign if_valid = !reset && resp_valid && (state == RUN);
  assign fault    = !reset && (state == FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
      resp_valid  <= 1'b0;
      fault_addr  <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        BOOT: begin
          resp_pc    <= fetch_pc;
          resp_valid <= 1'b1;
          fetch_pc   <= fetch_pc + 32'd4;
          state      <= RUN;
        end
        RUN: begin
          if (resp_valid && !stall) fetch_count <= fetch_count + 32'd1;
          if (fault_hit) begin
            // PCs hold so imem_addr freezes on the last good word.
            state      <= FAULT;
            fault_addr <= imem_addr;
            resp_valid <= 1'b0;
          end else if (redirect_valid) begin
            resp_pc    <= redirect_target;
            fetch_pc   <= redirect_target + 32'd4;
            resp_valid <= 1'b1;
          end else if (!stall) begin
            resp_pc    <= fetch_pc;
            fetch_pc   <= fetch_pc + 32'd4;
            resp_valid <= 1'b1;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a synchronous memory model feeds the DUT, and a
// monitor checks each delivered (pc, instr) against a queue of expected words.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mem [0:511];
  int          total = 0;
  int          bad   = 0;
  logic [9:0]  st_pat = 10'b0110101001;
  logic [9:0]  rv_pat = 10'b1011010110;

  fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .IMEM_BYTES  (2048)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_valid       (if_valid),
    .fault          (fault),
    .fault_addr     (fault_addr),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle registered read; upper address bits ignored so faulting reads stay in bounds.
  always @(posedge clk) imem_instr <= mem[imem_addr[10:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  // Inputs set here act on the output displayed at the following negedge.
  task automatic cyc(input logic st, input logic rv, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    stall           = st;
    redirect_valid  = rv;
    redirect_target = tgt;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    @(negedge clk);
    chk1("rst_valid", if_valid, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("boot_valid", if_valid, 1'b0);
    chk1("boot_fault", fault, 1'b0);
    chk("boot_faddr", fault_addr, 32'h0);
    chk("boot_count", fetch_count, 32'd0);
    chk("boot_addr", imem_addr, 32'h0);
  endtask

  // Scoreboard monitor: a word is delivered when valid and not stalled.
  always @(negedge clk) begin
    if (!reset && if_valid && !stall) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_delivery: pc %h instr %h with empty queue", if_pc, if_instr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("deliv_pc", if_pc, mon_e.pc);
        chk("deliv_instr", if_instr, mon_e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 | (32'(i) << 2);
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;

    // Reset release and first three sequential words
    do_reset();
    push(32'h0, 32'h0000_0013);
    push(32'h4, 32'h0010_0093);
    push(32'h8, 32'h0020_0113);
    cyc(1'b0, 1'b0, 32'h0);
    chk1("first_valid", if_valid, 1'b1);
    chk("first_count", fetch_count, 32'd0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h4);
    chk("seq_pc8", if_pc, 32'h8);
    chk("seq_count", fetch_count, 32'd2);

    // Re-fetch of 0x4, then stall three edges on it
    push(32'h4, 32'h0010_0093);
    for (int i = 0; i < 4; i++) begin
      cyc((i < 3) ? 1'b1 : 1'b0, 1'b0, 32'h0);
      chk("stall_pc", if_pc, 32'h4);
      chk("stall_instr", if_instr, 32'h0010_0093);
      chk1("stall_valid", if_valid, 1'b1);
      chk("stall_count", fetch_count, 32'd3);
    end
    push(32'h8, 32'h0020_0113);
    cyc(1'b0, 1'b1, 32'h40);
    chk("release_pc", if_pc, 32'h8);
    chk("release_count", fetch_count, 32'd4);

    // Redirect to 0x40 with no bubble
    push(32'h40, 32'hA000_0040);
    cyc(1'b0, 1'b0, 32'h0);
    chk("redir_pc", if_pc, 32'h40);
    chk1("redir_valid", if_valid, 1'b1);
    cyc(1'b1, 1'b1, 32'h10);
    chk("redir_next_pc", if_pc, 32'h44);
    chk("redir_next_instr", if_instr, 32'hA000_0044);
    chk("redir_count", fetch_count, 32'd6);

    // Stall+redirect together: redirect wins
    push(32'h10, 32'hA000_0010);
    cyc(1'b0, 1'b1, 32'h42);
    chk("sr_pc", if_pc, 32'h10);
    chk("sr_instr", if_instr, 32'hA000_0010);
    chk("misalign_addr", imem_addr, 32'h42);

    // Misaligned redirect faults and stays there
    for (int i = 0; i < 10; i++) begin
      cyc(st_pat[i], rv_pat[i], 32'h20 + (32'(i) << 2));
      chk1("mis_fault", fault, 1'b1);
      chk("mis_faddr", fault_addr, 32'h42);
      chk1("mis_valid", if_valid, 1'b0);
      chk("mis_count", fetch_count, 32'd7);
      chk("mis_frozen_addr", imem_addr, 32'h10);
    end

    // Run off the end of memory
    do_reset();
    push(32'h0, 32'h0000_0013);
    cyc(1'b0, 1'b1, 32'h7F0);
    push(32'h7F0, 32'hA000_07F0);
    push(32'h7F4, 32'hA000_07F4);
    push(32'h7F8, 32'hA000_07F8);
    push(32'h7FC, 32'hA000_07FC);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0);
    chk("last_pc", if_pc, 32'h7FC);
    chk("last_instr", if_instr, 32'hA000_07FC);
    chk("oob_addr", imem_addr, 32'h800);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk1("oob_fault", fault, 1'b1);
      chk("oob_faddr", fault_addr, 32'h800);
      chk1("oob_valid", if_valid, 1'b0);
      chk("oob_count", fetch_count, 32'd5);
      chk("oob_frozen_addr", imem_addr, 32'h7FC);
    end

    // Reset clears the fault and fetch restarts at the vector
    do_reset();
    push(32'h0, 32'h0000_0013);
    push(32'h4, 32'h0010_0093);
    cyc(1'b0, 1'b0, 32'h0);
    chk("restart_pc", if_pc, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("restart_count", fetch_count, 32'd1);
    cyc(1'b1, 1'b0, 32'h0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
